// File: rtl/logic_gates_seq_pkg.sv
// logic_gates_seq_pkg: shared op codes and key indices for the gate demo
package logic_gates_seq_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT_A = 3'd6;
  localparam logic [OP_W-1:0] OP_NOT_B = 3'd7;
  localparam int KEY_NEXT   = 0;
  localparam int KEY_PREV   = 1;
  localparam int KEY_FREEZE = 2;
  localparam int KEY_CLEAR  = 3;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce one active-low key, pulse once per press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic          s1, s2, state;
  logic [CW-1:0] cnt;
  logic          flip;
  assign flip    = (s2 != state) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign pressed = ~state;
  // synchroniser, stability counter and press-edge pulse
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      state       <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      s1          <= key_n;
      s2          <= s1;
      state       <= flip ? ~state : state;
      cnt         <= (s2 == state || flip) ? '0 : cnt + 1'b1;
      press_pulse <= flip & state;
    end
  end
endmodule

// File: rtl/logic_gates_seq.sv
// logic_gates_seq: key-selected bitwise gate on switch operands with freeze/clear
module logic_gates_seq
  import logic_gates_seq_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic [2*WIDTH-1:0]   SW,
  input  logic [3:0]           KEY,
  output logic [2*WIDTH-1:0]   LEDR,
  output logic [WIDTH-1:0]     LEDG,
  output logic [OP_W-1:0]      OP_SEL,
  output logic                 FROZEN
);
  logic [2*WIDTH-1:0] s_sw;
  logic [3:0]         pulse, keys_unused;
  logic [WIDTH-1:0]   a, b, res;
  logic [OP_W-1:0]    op_next;
  logic               frz_next, hold;
  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .key_n      (KEY[i]),
      .pressed    (keys_unused[i]),
      .press_pulse(pulse[i])
    );
  end
  assign a    = s_sw[WIDTH-1:0];
  assign b    = s_sw[2*WIDTH-1:WIDTH];
  assign LEDR = s_sw;
  // gate evaluation on the captured operands
  always_comb begin
    res = '0;
    case (OP_SEL)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NAND:  res = ~(a & b);
      OP_NOR:   res = ~(a | b);
      OP_XNOR:  res = ~(a ^ b);
      OP_NOT_A: res = ~a;
      OP_NOT_B: res = ~b;
      default:  res = '0;
    endcase
  end
  // op stepping and freeze toggling; clear wins over everything else
  always_comb begin
    op_next  = pulse[KEY_CLEAR] ? '0 :
               (pulse[KEY_NEXT] & ~pulse[KEY_PREV]) ? OP_SEL + 1'b1 :
               (pulse[KEY_PREV] & ~pulse[KEY_NEXT]) ? OP_SEL - 1'b1 : OP_SEL;
    frz_next = ~pulse[KEY_CLEAR] & (FROZEN ^ pulse[KEY_FREEZE]);
    hold     = FROZEN | frz_next;
  end
  // operand capture, control state and result register (held while frozen)
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s_sw   <= '0;
      LEDG   <= '0;
      OP_SEL <= '0;
      FROZEN <= 1'b0;
    end else begin
      s_sw   <= SW;
      LEDG   <= hold ? LEDG : res;
      OP_SEL <= op_next;
      FROZEN <= frz_next;
    end
  end
endmodule

// File: tb/tb_logic_gates_seq.sv
// tb_logic_gates_seq: directed checks of op stepping, debounce, freeze and reset
module tb_logic_gates_seq;
  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] SW;
  logic [3:0] KEY;
  logic [7:0] LEDR;
  logic [3:0] LEDG;
  logic [2:0] OP_SEL;
  logic       FROZEN;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] sweep [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0101, 4'b0011};

  logic_gates_seq #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk), .RESET(RESET), .SW(SW), .KEY(KEY),
    .LEDR(LEDR), .LEDG(LEDG), .OP_SEL(OP_SEL), .FROZEN(FROZEN)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] m);
    @(posedge clk); #1 KEY = KEY & ~m;
    repeat (8) @(posedge clk);
    #1 KEY = KEY | m;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 RESET = 1'b1;
    @(posedge clk); #1 RESET = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    RESET = 1'b1; SW = 8'hCA; KEY = 4'hF;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;
    @(negedge clk);
    chk("rst_ledr", LEDR, 8'h00);
    chk("rst_ledg", {4'h0, LEDG}, 8'h00);
    chk("rst_op", {5'h0, OP_SEL}, 8'h00);
    chk("rst_frozen", {7'h0, FROZEN}, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sweep_ledr", LEDR, 8'hCA);
    chk("sweep_ledg0", {4'h0, LEDG}, {4'h0, sweep[0]});
    for (int i = 1; i < 8; i++) begin
      press(4'b0001);
      chk($sformatf("sweep_op%0d", i), {5'h0, OP_SEL}, 8'(i));
      chk($sformatf("sweep_ledg%0d", i), {4'h0, LEDG}, {4'h0, sweep[i]});
    end
    press(4'b0001);
    chk("sweep_wrap", {5'h0, OP_SEL}, 8'h00);

    do_reset();
    @(posedge clk); #1 KEY[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 KEY[0] = 1'b1;
    @(posedge clk); #1 KEY[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 KEY[0] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bounce_op", {5'h0, OP_SEL}, 8'h00);
    @(posedge clk); #1 KEY[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lat_early", {5'h0, OP_SEL}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_step", {5'h0, OP_SEL}, 8'h01);
    repeat (33) @(posedge clk);
    @(negedge clk);
    chk("held_once", {5'h0, OP_SEL}, 8'h01);
    #1 KEY[0] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("release_nopulse", {5'h0, OP_SEL}, 8'h01);

    do_reset();
    press(4'b0010);
    chk("prev_wrap_op", {5'h0, OP_SEL}, 8'h07);
    chk("prev_wrap_ledg", {4'h0, LEDG}, 8'h03);
    press(4'b0011);
    chk("next_prev_op", {5'h0, OP_SEL}, 8'h07);
    press(4'b1001);
    chk("clear_wins_op", {5'h0, OP_SEL}, 8'h00);

    do_reset();
    press(4'b0001);
    press(4'b0001);
    chk("frz_pre_ledg", {4'h0, LEDG}, 8'h06);
    press(4'b0100);
    chk("frz_on", {7'h0, FROZEN}, 8'h01);
    @(posedge clk); #1 SW = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("frz_ledr", LEDR, 8'h00);
    repeat (3) @(negedge clk);
    chk("frz_ledg_sw", {4'h0, LEDG}, 8'h06);
    press(4'b0001);
    chk("frz_op", {5'h0, OP_SEL}, 8'h03);
    chk("frz_ledg_op", {4'h0, LEDG}, 8'h06);
    press(4'b0100);
    chk("unfrz_ledg", {4'h0, LEDG}, 8'h0F);
    chk("unfrz_flag", {7'h0, FROZEN}, 8'h00);

    SW = 8'hCA;
    do_reset();
    chk("lat_base", {4'h0, LEDG}, 8'h08);
    @(posedge clk); #1 SW = 8'hCF;
    @(negedge clk);
    chk("lat_ledr1", LEDR, 8'hCA);
    @(negedge clk);
    chk("lat_ledr2", LEDR, 8'hCF);
    chk("lat_ledg_hold", {4'h0, LEDG}, 8'h08);
    @(negedge clk);
    chk("lat_ledg2", {4'h0, LEDG}, 8'h0C);

    SW = 8'hCA;
    do_reset();
    for (int i = 0; i < 5; i++) press(4'b0001);
    press(4'b0100);
    chk("mid_op", {5'h0, OP_SEL}, 8'h05);
    chk("mid_frz", {7'h0, FROZEN}, 8'h01);
    @(posedge clk); #1 KEY[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b1;
    @(posedge clk); #1 RESET = 1'b0;
    @(negedge clk);
    chk("mid_rst_ledr", LEDR, 8'h00);
    chk("mid_rst_ledg", {4'h0, LEDG}, 8'h00);
    chk("mid_rst_op", {5'h0, OP_SEL}, 8'h00);
    chk("mid_rst_frz", {7'h0, FROZEN}, 8'h00);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_held_early", {5'h0, OP_SEL}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_held_step", {5'h0, OP_SEL}, 8'h01);
    #1 KEY[0] = 1'b1;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
